// File: rtl/prom_access_arbiter.sv
// prom_access_arbiter: shares one 256x4 registered-output PROM between two requesters.
//   Port A  - high-priority 4-bit nibble reads, one per cycle, data one cycle after grant.
//   Port B  - 8-bit byte reads built from nibbles {0,addr} (low) and {1,addr} (high), issued
//             as an atomic two-cycle sequence; b_rvalid pulses three cycles after the grant.
//   A starvation counter forces B ahead of A after STARVE_MAX consecutive denied cycles.
// Ports:
//   clk, reset (async, active-low)
//   a_req/a_addr -> a_gnt (comb), a_rvalid/a_rdata
//   b_req/b_addr -> b_gnt (comb), b_rvalid/b_rdata (held between pulses)
//   prom_addr, prom_ce1_b, prom_ce2_b -> PROM; prom_data <- PROM (valid the cycle after issue)
module prom_access_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_req,
  input  logic [7:0] a_addr,
  output logic       a_gnt,
  output logic       a_rvalid,
  output logic [3:0] a_rdata,
  input  logic       b_req,
  input  logic [6:0] b_addr,
  output logic       b_gnt,
  output logic       b_rvalid,
  output logic [7:0] b_rdata,
  output logic [7:0] prom_addr,
  output logic       prom_ce1_b,
  output logic       prom_ce2_b,
  input  logic [3:0] prom_data
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [0:0] {StIdle, StBHi} state_e;

  state_e      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [6:0]  b_addr_q;
  logic [3:0]  b_lo_q;
  logic        a_rvalid_q;
  logic        b_hi_pend_q;   // high nibble of a B read is on prom_data this cycle
  logic        b_rvalid_q;
  logic [7:0]  b_rdata_q;
  logic        issue;
  logic        b_force;

  always_comb begin
    state_d   = state_q;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    prom_addr = 8'h00;
    issue     = 1'b0;
    b_force   = b_req && (starve_cnt_q == StarveMax);

    unique case (state_q)
      StIdle: begin
        // Grants are combinational from the requests, so hold them off during reset.
        if (reset) begin
          if (b_force) begin
            b_gnt = 1'b1;
          end else if (a_req) begin
            a_gnt = 1'b1;
          end else if (b_req) begin
            b_gnt = 1'b1;
          end
        end
        if (a_gnt) begin
          issue     = 1'b1;
          prom_addr = a_addr;
        end else if (b_gnt) begin
          issue     = 1'b1;
          prom_addr = {1'b0, b_addr};
          state_d   = StBHi;
        end
      end
      StBHi: begin
        issue     = 1'b1;
        prom_addr = {1'b1, b_addr_q};
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Counts every denied requesting cycle, including the atomic B_HI cycle.
    if (!b_req || b_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q < StarveMax) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      starve_cnt_q <= 4'd0;
      b_addr_q     <= 7'h00;
      b_lo_q       <= 4'h0;
      a_rvalid_q   <= 1'b0;
      b_hi_pend_q  <= 1'b0;
      b_rvalid_q   <= 1'b0;
      b_rdata_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      a_rvalid_q   <= a_gnt;
      b_hi_pend_q  <= (state_q == StBHi);
      b_rvalid_q   <= b_hi_pend_q;
      if (b_gnt) begin
        b_addr_q <= b_addr;
      end
      // Low nibble returns while the high half is being issued.
      if (state_q == StBHi) begin
        b_lo_q <= prom_data;
      end
      if (b_hi_pend_q) begin
        b_rdata_q <= {prom_data, b_lo_q};
      end
    end
  end

  assign a_rvalid   = a_rvalid_q;
  assign a_rdata    = a_rvalid_q ? prom_data : 4'h0;
  assign b_rvalid   = b_rvalid_q;
  assign b_rdata    = b_rdata_q;
  assign prom_ce1_b = ~issue;
  assign prom_ce2_b = ~issue;

endmodule

// File: tb/tb_prom_access_arbiter.sv
module tb_prom_access_arbiter;

  localparam int SM = 4;

  logic       clk;
  logic       reset;
  logic       a_req;
  logic [7:0] a_addr;
  logic       a_gnt;
  logic       a_rvalid;
  logic [3:0] a_rdata;
  logic       b_req;
  logic [6:0] b_addr;
  logic       b_gnt;
  logic       b_rvalid;
  logic [7:0] b_rdata;
  logic [7:0] prom_addr;
  logic       prom_ce1_b;
  logic       prom_ce2_b;
  wire  [3:0] prom_data;

  prom_access_arbiter #(.STARVE_MAX(SM)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_req     (a_req),
    .a_addr    (a_addr),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_addr    (b_addr),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .prom_addr (prom_addr),
    .prom_ce1_b(prom_ce1_b),
    .prom_ce2_b(prom_ce2_b),
    .prom_data (prom_data)
  );

  // Behavioural 82S129-style PROM: registered output, Z when not enabled last cycle.
  logic [3:0] mem [256];
  logic [3:0] prom_q;
  logic       prom_v;
  always @(posedge clk) begin
    prom_v <= !prom_ce1_b && !prom_ce2_b;
    prom_q <= mem[prom_addr];
  end
  assign prom_data = prom_v ? prom_q : 4'bz;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       a_q[$];
  exp_t       b_q[$];
  logic [7:0] last_b = 8'h00;

  // Reference model: B_HI occupancy, B wait streak, and latched B address.
  logic       m_hi = 1'b0;
  int         m_wait = 0;
  logic [6:0] m_baddr = 7'h00;

  task automatic drive_cycle(input logic ar, input logic [7:0] aa, input logic br,
                             input logic [6:0] ba, output logic ga, output logic gb);
    logic       ea, eb;
    logic [7:0] eaddr;
    exp_t       e;
    @(negedge clk);
    a_req = ar; a_addr = aa; b_req = br; b_addr = ba;
    #1;
    ea = 1'b0;
    eb = 1'b0;
    if (m_hi) begin
      ea = 1'b0;
    end else if (br && m_wait >= SM) begin
      eb = 1'b1;
    end else if (ar) begin
      ea = 1'b1;
    end else if (br) begin
      eb = 1'b1;
    end
    eaddr = ea ? aa : eb ? {1'b0, ba} : m_hi ? {1'b1, m_baddr} : 8'h00;
    chk("a_gnt", int'(a_gnt), int'(ea));
    chk("b_gnt", int'(b_gnt), int'(eb));
    chk("prom_addr", int'(prom_addr), int'(eaddr));
    chk("prom_ce1_b", int'(prom_ce1_b), int'(!(ea || eb || m_hi)));
    chk("prom_ce2_b", int'(prom_ce2_b), int'(!(ea || eb || m_hi)));
    if (ea) begin
      e.data = {4'h0, mem[aa]};
      e.due  = cyc + 1;
      a_q.push_back(e);
    end
    if (eb) begin
      e.data = {mem[{1'b1, ba}], mem[{1'b0, ba}]};
      e.due  = cyc + 3;
      b_q.push_back(e);
      m_baddr = ba;
    end
    if (br && !eb) m_wait = (m_wait < SM) ? m_wait + 1 : m_wait;
    else           m_wait = 0;
    m_hi = eb;
    ga = ea;
    gb = eb;
  endtask

  // Monitor: compares every returned read against the scoreboard, including latency.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (a_rvalid) begin
        if (a_q.size() == 0) begin
          chk("a_unexpected_rvalid", 1, 0);
        end else begin
          e = a_q.pop_front();
          chk("a_rdata", int'(a_rdata), int'(e.data));
          chk("a_latency", cyc, e.due);
        end
      end else begin
        chk("a_rdata_idle", int'(a_rdata), 0);
        if (a_q.size() > 0 && a_q[0].due <= cyc) begin
          chk("a_missing_rvalid", 0, 1);
          void'(a_q.pop_front());
        end
      end
      if (b_rvalid) begin
        if (b_q.size() == 0) begin
          chk("b_unexpected_rvalid", 1, 0);
        end else begin
          e = b_q.pop_front();
          chk("b_rdata", int'(b_rdata), int'(e.data));
          chk("b_latency", cyc, e.due);
          last_b = e.data;
        end
      end else begin
        chk("b_rdata_hold", int'(b_rdata), int'(last_b));
        if (b_q.size() > 0 && b_q[0].due <= cyc) begin
          chk("b_missing_rvalid", 0, 1);
          void'(b_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1);
  end

  task automatic idle(input int n);
    logic ga, gb;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00, 1'b0, 7'h00, ga, gb);
  endtask

  initial begin
    logic       ga, gb, ap, bp;
    logic [7:0] aa;
    logic [6:0] ba;

    for (int i = 0; i < 256; i++) mem[i] = 4'($urandom);
    mem[8'h05] = 4'hA;
    mem[8'h85] = 4'h3;
    for (int i = 0; i < 8; i++) mem[8'h10 + i] = 4'(i);

    // Reset state, with requests asserted to show grants are held off.
    reset = 1'b0; a_req = 1'b1; a_addr = 8'h10; b_req = 1'b1; b_addr = 7'h05;
    #3;
    chk("rst_a_gnt", int'(a_gnt), 0);
    chk("rst_b_gnt", int'(b_gnt), 0);
    chk("rst_ce1", int'(prom_ce1_b), 1);
    chk("rst_ce2", int'(prom_ce2_b), 1);
    chk("rst_prom_addr", int'(prom_addr), 0);
    chk("rst_a_rvalid", int'(a_rvalid), 0);
    chk("rst_b_rvalid", int'(b_rvalid), 0);
    chk("rst_b_rdata", int'(b_rdata), 0);
    a_req = 1'b0; b_req = 1'b0;
    #20 reset = 1'b1;

    // Single A read, then 8 back-to-back.
    drive_cycle(1'b1, 8'h10, 1'b0, 7'h00, ga, gb);
    idle(2);
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 8'h10 + 8'(i), 1'b0, 7'h00, ga, gb);
    idle(2);

    // B read of 0x05 alone.
    drive_cycle(1'b0, 8'h00, 1'b1, 7'h05, ga, gb);
    idle(5);

    // A request arriving during B_HI waits one cycle.
    drive_cycle(1'b0, 8'h00, 1'b1, 7'h05, ga, gb);
    drive_cycle(1'b1, 8'h11, 1'b0, 7'h00, ga, gb);
    drive_cycle(1'b1, 8'h11, 1'b0, 7'h00, ga, gb);
    idle(5);

    // Starvation: continuous A traffic, B raised at T.
    aa = 8'h10;
    bp = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b1, aa, bp, 7'h05, ga, gb);
      if (ga) aa = aa + 8'h01;
      if (bp && gb) begin
        chk("starve_grant_offset", int'(b_gnt) * i, 4);
        bp = 1'b0;
      end
    end
    idle(5);

    // Reset during B_HI aborts the byte read.
    drive_cycle(1'b0, 8'h00, 1'b1, 7'h05, ga, gb);
    @(negedge clk);
    b_req = 1'b0;
    #1;
    chk("bhi_prom_addr", int'(prom_addr), 8'h85);
    chk("bhi_ce1", int'(prom_ce1_b), 0);
    a_req = 1'b1; a_addr = 8'h12;
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_ce1", int'(prom_ce1_b), 1);
    chk("mid_rst_ce2", int'(prom_ce2_b), 1);
    chk("mid_rst_prom_addr", int'(prom_addr), 0);
    chk("mid_rst_a_gnt", int'(a_gnt), 0);
    chk("mid_rst_b_rdata", int'(b_rdata), 0);
    chk("mid_rst_a_rdata", int'(a_rdata), 0);
    a_q.delete();
    b_q.delete();
    last_b = 8'h00;
    m_hi = 1'b0;
    m_wait = 0;
    a_req = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    idle(5);
    drive_cycle(1'b0, 8'h00, 1'b1, 7'h05, ga, gb);
    idle(5);

    // Randomized traffic obeying hold-until-grant, with occasional request withdrawal.
    ap = 1'b0; bp = 1'b0; aa = 8'h00; ba = 7'h00;
    for (int i = 0; i < 3000; i++) begin
      if (!ap && $urandom_range(0, 99) < 60) begin
        ap = 1'b1;
        aa = 8'($urandom);
      end else if (ap && $urandom_range(0, 99) < 3) begin
        ap = 1'b0;
      end
      if (!bp && $urandom_range(0, 99) < 30) begin
        bp = 1'b1;
        ba = 7'($urandom);
      end else if (bp && $urandom_range(0, 99) < 2) begin
        bp = 1'b0;
      end
      drive_cycle(ap, aa, bp, ba, ga, gb);
      if (ga) ap = 1'b0;
      if (gb) bp = 1'b0;
    end
    idle(6);

    chk("a_queue_drained", a_q.size(), 0);
    chk("b_queue_drained", b_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prom_access_arbiter.md
Name: prom_access_arbiter

Overview:
Shares one 256x4 control PROM (82S129-style: registered output, two active-low chip enables, output is Z when disabled) between two requesters. Port A is the video-timing path: 4-bit nibble reads, high priority, pipelined one per cycle. Port B is the slower byte path: 8-bit reads assembled from two nibbles at {0,addr} (low) and {1,addr} (high), issued as an atomic two-cycle sequence. A starvation guard guarantees B forward progress under continuous A traffic.

Parameters:
STARVE_MAX, 4, consecutive cycles B may be denied while requesting before B is forced ahead of A (legal range 1..15)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
a_req  input  1  port A read request
a_addr  input  8  port A nibble address, sampled in grant cycle
a_gnt  output  1  A request issued to PROM this cycle (combinational)
a_rvalid  output  1  a_rdata valid (registered)
a_rdata  output  4  A read data
b_req  input  1  port B byte read request
b_addr  input  7  port B byte address, sampled in grant cycle
b_gnt  output  1  B request accepted this cycle (combinational)
b_rvalid  output  1  b_rdata valid, one-cycle pulse (registered)
b_rdata  output  8  B read data {hi nibble, lo nibble}, registered, held between pulses
prom_addr  output  8  PROM address
prom_ce1_b  output  1  PROM chip enable 1, active-low
prom_ce2_b  output  1  PROM chip enable 2, active-low
prom_data  input  4  PROM registered output

Behaviour:
- PROM timing: an issue cycle drives prom_addr and CEs low; data is valid on prom_data during the next cycle. prom_data is sampled or forwarded only in the cycle after an issue; it is Z otherwise.
- prom_ce1_b = prom_ce2_b = ~issue. prom_addr is 8'h00 in non-issue cycles.
- States:
  - IDLE: may issue A or the B low half.
  - B_HI: issues the B high half. Atomic: a_gnt=0 and b_gnt=0. Always returns to IDLE next cycle.
- IDLE grant rule:
  - If b_req and starve_cnt==STARVE_MAX: B wins.
  - Else if a_req: A wins.
  - Else if b_req: B wins.
- A issue: a_gnt=1, prom_addr=a_addr.
  - Next cycle: a_rvalid=1, a_rdata=prom_data.
  - Otherwise a_rvalid=0 and a_rdata=4'h0.
  - Throughput: one A read per cycle, fully pipelined.
- B issue (IDLE): b_gnt=1, prom_addr={1'b0,b_addr}, b_addr latched, go to B_HI.
  - B_HI cycle: prom_addr={1'b1,latched}; the low nibble is captured from prom_data.
  - Following cycle (IDLE again): the high nibble is captured; b_rdata={hi,lo} is registered.
  - b_rvalid pulses 1 cycle later, i.e. 3 cycles after the grant cycle (grant T, b_rvalid high during T+3).
  - A may issue in the cycle the high nibble returns. The registered B return pipeline does not block IDLE.
  - A new B grant is allowed in that same cycle.
- starve_cnt (4-bit):
  - Increments (saturating at STARVE_MAX) each cycle b_req=1 and b_gnt=0, including B_HI cycles.
  - Clears on b_gnt or when b_req=0.
- Simultaneous a_req and b_req with starve_cnt<STARVE_MAX: A granted, B counts.
- Request rules: requesters hold req and addr until gnt. Dropping req before gnt is allowed and has no side effect.
- Reset (async assert, sync release): state IDLE, starve_cnt 0, a_rvalid 0, b_rvalid 0, a_rdata 0, b_rdata 8'h00, CEs 1, prom_addr 0, gnts 0.
  - Reset mid-B aborts: no b_rvalid after release. In-flight A data is discarded.

Test Plan:
PROM preload: mem[0x05]=0xA, mem[0x85]=0x3, mem[0x10..0x17]=0x0..0x7.
- A single read, a_addr=0x10, B idle -> a_gnt same cycle, CEs low; next cycle a_rvalid=1, a_rdata=0x0.
- A back-to-back, a_addr 0x10..0x17 on 8 consecutive cycles -> 8 consecutive a_rvalid pulses with data 0x0..0x7 in order; CEs low all 8 cycles.
- B read, b_addr=0x05, A idle, grant cycle T -> prom_addr 0x05 at T, 0x85 at T+1; b_rvalid only at T+3 with b_rdata=0x3A; CEs high from T+2.
- a_req asserted at T+1 of the B sequence -> a_gnt=0 at T+1, a_gnt=1 at T+2, a_rvalid at T+3.
- Starvation, STARVE_MAX=4: a_req held high continuously, b_req raised at T -> A granted T..T+3, b_gnt at T+4 with starve_cnt==4; A stalled at T+5; A resumes T+6; starve_cnt=0 after grant.
- Reset asserted during B_HI -> CEs high and outputs zero immediately; after release, no b_rvalid; next B read of 0x05 returns 0x3A normally.
